// File: rtl/qei_velocity.sv
// qei_velocity: periodic velocity estimator for a quadrature position counter.
// Samples the 32-bit position once per PERIOD cycles, forms the modular
// difference to the previous sample and saturates it to VEL_WIDTH bits.
// The result is offered to a consumer over a valid/ready handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_PRIME | waiting for the first tick to capture a reference position
// ST_RUN   | reference held; every tick produces a velocity sample
module qei_velocity #(
    parameter int PERIOD    = 50000,
    parameter int VEL_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [31:0]          position,
    output logic [VEL_WIDTH-1:0] vel_data,
    output logic                 vel_valid,
    input  logic                 vel_ready,
    output logic                 vel_saturated,
    output logic                 overrun
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    // Clip limits held at 64 bits so VEL_WIDTH=32 needs no special casing.
    localparam logic signed [63:0] VEL_MAX = (64'sd1 <<< (VEL_WIDTH - 1)) - 64'sd1;
    localparam logic signed [63:0] VEL_MIN = -(64'sd1 <<< (VEL_WIDTH - 1));

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]     count;
    logic                 tick;
    logic [31:0]          last_position;
    logic [31:0]          delta;
    logic signed [63:0]   delta_ext;
    logic [VEL_WIDTH-1:0] vel_clip;
    logic                 clip_hit;
    logic                 load_sample;
    logic                 accept;
    logic                 vel_valid_next;
    logic                 overrun_next;

    // Sample-interval timer: runs 0..PERIOD-1 while enabled, parks at 0 otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!enable) begin
            count <= '0;
        end else if (count == CNT_LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = enable && (count == CNT_LAST);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_PRIME;
        end else begin
            state <= state_next;
        end
    end

    // Next state: disabling always re-primes; the first tick arms RUN.
    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = ST_PRIME;
        end else if (tick) begin
            state_next = ST_RUN;
        end
    end

    // Output/control decode: sample load, consumer accept, flag updates.
    always_comb begin
        load_sample    = (state == ST_RUN) && tick;
        accept         = vel_valid && vel_ready;
        vel_valid_next = vel_valid;
        overrun_next   = overrun;
        if (!enable) begin
            vel_valid_next = 1'b0;
            overrun_next   = 1'b0;
        end else if (load_sample) begin
            vel_valid_next = 1'b1;
            if (vel_valid && !vel_ready) begin
                overrun_next = 1'b1;
            end
        end else if (accept) begin
            vel_valid_next = 1'b0;
        end
    end

    // Modular difference, so a counter wrap still yields the small true delta.
    assign delta     = position - last_position;
    assign delta_ext = {{32{delta[31]}}, delta};

    // Saturate the signed delta into the output width.
    always_comb begin
        clip_hit = 1'b0;
        vel_clip = delta[VEL_WIDTH-1:0];
        if (delta_ext > VEL_MAX) begin
            clip_hit = 1'b1;
            vel_clip = VEL_MAX[VEL_WIDTH-1:0];
        end else if (delta_ext < VEL_MIN) begin
            clip_hit = 1'b1;
            vel_clip = VEL_MIN[VEL_WIDTH-1:0];
        end
    end

    // Reference position is refreshed on every tick, priming or running.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_position <= '0;
        end else if (tick) begin
            last_position <= position;
        end
    end

    // Velocity word and its saturation flag move together, only on a load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vel_data      <= '0;
            vel_saturated <= 1'b0;
        end else if (load_sample) begin
            vel_data      <= vel_clip;
            vel_saturated <= clip_hit;
        end
    end

    // Handshake valid and sticky overrun flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vel_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            vel_valid <= vel_valid_next;
            overrun   <= overrun_next;
        end
    end

endmodule

// File: tb/tb_qei_velocity.sv
// Testbench for qei_velocity: table-driven sample vectors, hand-written
// handshake/reset/enable sequences and a randomized run, all compared
// against a cycle-level behavioural model kept in the bench.
module tb_qei_velocity;

    localparam int P  = 8;
    localparam int VW = 8;
    localparam longint VMAX = (64'sd1 <<< (VW - 1)) - 1;
    localparam longint VMIN = -(64'sd1 <<< (VW - 1));

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [31:0]   position = '0;
    logic [VW-1:0] vel_data;
    logic          vel_valid;
    logic          vel_ready = 1'b0;
    logic          vel_saturated;
    logic          overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int            m_run = 0;
    bit            m_primed = 0;
    logic [31:0]   m_last = '0;
    logic [VW-1:0] m_data = '0;
    bit            m_sat = 0;
    bit            m_valid = 0;
    bit            m_ovr = 0;

    typedef struct {
        logic [31:0]   pos;
        logic          prime;
        logic [VW-1:0] exp_data;
        logic          exp_sat;
    } vec_t;

    vec_t tbl[12];

    qei_velocity #(.PERIOD(P), .VEL_WIDTH(VW)) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .position(position),
        .vel_data(vel_data),
        .vel_valid(vel_valid),
        .vel_ready(vel_ready),
        .vel_saturated(vel_saturated),
        .overrun(overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: ticks fall on every PERIOD-th enabled cycle, the
    // first one after (re)start only records the reference position.
    task automatic model_step();
        bit     tk;
        bit     acc;
        longint d;
        if (reset) begin
            m_run = 0; m_primed = 0; m_last = '0;
            m_data = '0; m_sat = 0; m_valid = 0; m_ovr = 0;
            return;
        end
        if (!enable) begin
            m_run = 0; m_primed = 0; m_valid = 0; m_ovr = 0;
            return;
        end
        tk  = ((m_run % P) == P - 1);
        acc = m_valid && vel_ready;
        m_run++;
        if (tk && m_primed) begin
            d = longint'($signed(position - m_last));
            if (d > VMAX) begin
                m_data = VW'(VMAX); m_sat = 1;
            end else if (d < VMIN) begin
                m_data = VW'(VMIN); m_sat = 1;
            end else begin
                m_data = VW'(d); m_sat = 0;
            end
            if (m_valid && !vel_ready) m_ovr = 1;
            m_valid = 1;
        end else if (acc) begin
            m_valid = 0;
        end
        if (tk) begin
            m_last   = position;
            m_primed = 1;
        end
    endtask

    task automatic cmp_model();
        check("model_valid", 32'(vel_valid), 32'(m_valid));
        check("model_data", 32'(vel_data), 32'(m_data));
        check("model_sat", 32'(vel_saturated), 32'(m_sat));
        check("model_overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic cycle(input logic en, input logic [31:0] pos, input logic rdy);
        @(negedge clock);
        enable    = en;
        position  = pos;
        vel_ready = rdy;
        @(posedge clock);
        model_step();
        #1;
        cmp_model();
    endtask

    // One full sample period at a constant position; the last cycle is the tick.
    task automatic period(input logic [31:0] pos, input logic rdy_mid, input logic rdy_tick);
        for (int i = 0; i < P - 1; i++) cycle(1'b1, pos, rdy_mid);
        cycle(1'b1, pos, rdy_tick);
    endtask

    initial begin
        int          first_valid;
        int          n_valid;
        bit          prev_valid;
        logic [31:0] pos;

        tbl[0]  = '{32'hFFFF_FFFC, 1'b1, 8'h00, 1'b0};
        tbl[1]  = '{32'h0000_0004, 1'b0, 8'h08, 1'b0};
        tbl[2]  = '{32'hFFFF_FFFC, 1'b0, 8'hF8, 1'b0};
        tbl[3]  = '{32'h0000_0128, 1'b0, 8'h7F, 1'b1};
        tbl[4]  = '{32'hFFFF_FFFC, 1'b0, 8'h80, 1'b1};
        tbl[5]  = '{32'h0000_0001, 1'b0, 8'h05, 1'b0};
        tbl[6]  = '{32'h0000_0080, 1'b0, 8'h7F, 1'b0};
        tbl[7]  = '{32'h0000_0100, 1'b0, 8'h7F, 1'b1};
        tbl[8]  = '{32'h0000_0080, 1'b0, 8'h80, 1'b0};
        tbl[9]  = '{32'hFFFF_FFFF, 1'b0, 8'h80, 1'b1};
        tbl[10] = '{32'h7FFF_FFFF, 1'b0, 8'h80, 1'b1};
        tbl[11] = '{32'h7FFF_FFFF, 1'b0, 8'h00, 1'b0};

        // reset state
        @(posedge clock);
        #1;
        check("rst_valid", 32'(vel_valid), 32'd0);
        check("rst_data", 32'(vel_data), 32'd0);
        check("rst_sat", 32'(vel_saturated), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // table-driven samples: wrap, saturation and clip boundaries
        cycle(1'b0, 32'd0, 1'b1);
        foreach (tbl[k]) begin
            period(tbl[k].pos, 1'b1, 1'b1);
            check("tbl_valid", 32'(vel_valid), 32'(!tbl[k].prime));
            if (!tbl[k].prime) begin
                check("tbl_data", 32'(vel_data), 32'(tbl[k].exp_data));
                check("tbl_sat", 32'(vel_saturated), 32'(tbl[k].exp_sat));
            end
        end

        // steady rate: +1 per cycle gives +8 per period, valid one cycle each
        cycle(1'b0, 32'd0, 1'b1);
        pos = 32'h1234_0000;
        first_valid = 0; n_valid = 0; prev_valid = 0;
        for (int c = 1; c <= 5 * P; c++) begin
            cycle(1'b1, pos, 1'b1);
            pos++;
            if (vel_valid) begin
                n_valid++;
                if (first_valid == 0) first_valid = c;
                check("steady_data", 32'(vel_data), 32'd8);
                check("steady_sat", 32'(vel_saturated), 32'd0);
                check("steady_single_cycle", 32'(prev_valid), 32'd0);
            end
            prev_valid = vel_valid;
        end
        check("steady_first_valid", 32'(first_valid), 32'(2 * P));
        check("steady_count", 32'(n_valid), 32'd4);

        // overrun and handshake
        cycle(1'b0, 32'd0, 1'b0);
        period(32'd100, 1'b0, 1'b0);
        check("prime_no_valid", 32'(vel_valid), 32'd0);
        period(32'd103, 1'b0, 1'b0);
        check("ovr_first_data", 32'(vel_data), 32'd3);
        check("ovr_first_flag", 32'(overrun), 32'd0);
        period(32'd110, 1'b0, 1'b0);
        check("ovr_data", 32'(vel_data), 32'd7);
        check("ovr_valid", 32'(vel_valid), 32'd1);
        check("ovr_flag", 32'(overrun), 32'd1);
        cycle(1'b1, 32'd110, 1'b1);
        check("accept_valid", 32'(vel_valid), 32'd0);
        check("accept_overrun_sticky", 32'(overrun), 32'd1);
        for (int i = 0; i < P - 2; i++) cycle(1'b1, 32'd110, 1'b0);
        cycle(1'b1, 32'd115, 1'b0);
        check("reload_data", 32'(vel_data), 32'd5);
        period(32'd124, 1'b0, 1'b1);
        check("acc_tick_valid", 32'(vel_valid), 32'd1);
        check("acc_tick_data", 32'(vel_data), 32'd9);
        check("acc_tick_overrun", 32'(overrun), 32'd1);

        // enable drop mid-period
        cycle(1'b1, 32'd124, 1'b0);
        cycle(1'b1, 32'd124, 1'b0);
        cycle(1'b0, 32'd999, 1'b1);
        check("dis_valid", 32'(vel_valid), 32'd0);
        check("dis_overrun", 32'(overrun), 32'd0);
        check("dis_data_held", 32'(vel_data), 32'd9);
        period(32'd200, 1'b0, 1'b0);
        check("reprime_no_valid", 32'(vel_valid), 32'd0);
        period(32'd204, 1'b0, 1'b0);
        check("reen_valid", 32'(vel_valid), 32'd1);
        check("reen_data", 32'(vel_data), 32'd4);
        period(32'd210, 1'b0, 1'b1);
        check("acc_tick2_valid", 32'(vel_valid), 32'd1);
        check("acc_tick2_data", 32'(vel_data), 32'd6);
        check("acc_tick2_no_overrun", 32'(overrun), 32'd0);

        // asynchronous reset while a sample is pending
        cycle(1'b1, 32'd210, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(vel_valid), 32'd0);
        check("async_rst_data", 32'(vel_data), 32'd0);
        check("async_rst_sat", 32'(vel_saturated), 32'd0);
        check("async_rst_overrun", 32'(overrun), 32'd0);
        cycle(1'b1, 32'd300, 1'b1);
        reset = 1'b0;
        first_valid = 0;
        pos = 32'd300;
        for (int c = 1; c <= 3 * P && first_valid == 0; c++) begin
            pos = pos + 32'd3;
            cycle(1'b1, pos, 1'b1);
            if (vel_valid) first_valid = c;
        end
        check("post_rst_first_valid", 32'(first_valid), 32'(2 * P));

        // randomized run against the model
        pos = $urandom;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 31) == 0) pos = $urandom;
            else pos = pos + 32'($urandom_range(0, 400)) - 32'd200;
            cycle($urandom_range(0, 99) != 0, pos, $urandom_range(0, 2) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
